// File: rtl/regfile_2r1w_clr.sv
// Two-read/one-write register file: r0 reads as zero, a clear request (or reset) zeroes the file one entry per cycle.
// Define REGFILE_BYPASS_EN to forward an accepted write to matching read ports in the same cycle.
module regfile_2r1w_clr #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [WIDTH-1:0]  rdata1_o,
    output logic [WIDTH-1:0]  rdata2_o,
    output logic              busy_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              busy;
    logic              wr_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    assign busy   = (state_q == CLEAR);
    assign wr_acc = we_i && (waddr_i != '0) && !busy;
    assign busy_o = busy;

    // Entry 0 is never written; the sequence starts at 1 and reads of 0 are masked.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        if (state_q == IDLE) begin
            mem_we = wr_acc;
            if (clr_req_i) begin
                state_d = CLEAR;
                cnt_d   = FIRST_IDX;
            end
        end else begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset leaves the array alone; zeroing happens only through the sequence.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rdata1_o = '0;
        if (!busy && (raddr1_i != '0)) begin
            rdata1_o = mem_q[raddr1_i];
`ifdef REGFILE_BYPASS_EN
            if (wr_acc && (raddr1_i == waddr_i)) begin
                rdata1_o = wdata_i;
            end
`endif
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (!busy && (raddr2_i != '0)) begin
            rdata2_o = mem_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
            if (wr_acc && (raddr2_i == waddr_i)) begin
                rdata2_o = wdata_i;
            end
`endif
        end
    end
endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Scoreboard bench for regfile_2r1w_clr: a behavioural model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_regfile_2r1w_clr;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int CLR_CYCLES = 31;

    logic        clk = 1'b0;
    logic        rst_i, clr_req_i, we_i;
    logic [4:0]  waddr_i, raddr1_i, raddr2_i;
    logic [31:0] wdata_i, rdata1_o, rdata2_o;
    logic        busy_o;

    always #5 clk = ~clk;

    regfile_2r1w_clr #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .clr_req_i(clr_req_i), .we_i(we_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
        .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic        busy;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m [32];
    int          busy_left = 0;
    bit          model_valid = 1'b0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] exp_rd(logic [4:0] a, logic we, logic [4:0] wa, logic [31:0] wd);
        if (busy_left > 0 || a == 5'd0) return 32'h0;
        if (BYPASS && we && wa != 5'd0 && a == wa) return wd;
        return mem_m[a];
    endfunction

    // Applies one cycle of stimulus, predicts that cycle's outputs, then advances the model.
    task automatic drive(input logic rst, input logic clr, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        rst_i = rst; clr_req_i = clr; we_i = we; waddr_i = wa; wdata_i = wd;
        raddr1_i = a1; raddr2_i = a2;
        if (model_valid) begin
            e.busy = (busy_left > 0);
            e.r1   = exp_rd(a1, we, wa, wd);
            e.r2   = exp_rd(a2, we, wa, wd);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            busy_left   = CLR_CYCLES;
            model_valid = 1'b1;
            foreach (mem_m[i]) mem_m[i] = 32'h0;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (we && wa != 5'd0) mem_m[wa] = wd;
            if (clr) begin
                foreach (mem_m[i]) mem_m[i] = 32'h0;
                busy_left = CLR_CYCLES;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] a1, input logic [4:0] a2);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, a1, a2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks += 3;
            if (busy_o !== e.busy) begin
                errors++;
                $display("FAIL busy @%0t: got %0b expected %0b", $time, busy_o, e.busy);
            end
            if (rdata1_o !== e.r1) begin
                errors++;
                $display("FAIL rdata1 @%0t addr %0d: got %08h expected %08h", $time, raddr1_i, rdata1_o, e.r1);
            end
            if (rdata2_o !== e.r2) begin
                errors++;
                $display("FAIL rdata2 @%0t addr %0d: got %08h expected %08h", $time, raddr2_i, rdata2_o, e.r2);
            end
        end
    end

    initial begin
        rst_i = 1'b1; clr_req_i = 1'b0; we_i = 1'b0;
        waddr_i = '0; wdata_i = '0; raddr1_i = '0; raddr2_i = '0;

        // Reset held two cycles, then the 31-cycle clear and a full zero scan.
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        drive(1'b1, 1'b0, 1'b1, 5'd4, 32'hFFFF_FFFF, 5'd4, 5'd31);
        idle(CLR_CYCLES + 2, 5'd31, 5'd1);
        for (int a = 0; a < 32; a++) idle(1, 5'(a), 5'(31 - a));

        // Basic write and r0 protection.
        drive(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd5);
        idle(1, 5'd5, 5'd0);
        idle(1, 5'd0, 5'd5);

        // Same-cycle write/read on r7.
        drive(1'b0, 1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd7);
        idle(1, 5'd7, 5'd7);

        // Clear request with a coincident write; write during busy is dropped.
        drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h1111_1111, 5'd9, 5'd9);
        drive(1'b0, 1'b1, 1'b1, 5'd10, 32'h2222_2222, 5'd9, 5'd10);
        idle(5, 5'd9, 5'd10);
        drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h3333_3333, 5'd3, 5'd10);
        idle(CLR_CYCLES, 5'd3, 5'd9);
        idle(2, 5'd10, 5'd3);

        // Reset in the middle of a clear restarts the full sequence.
        drive(1'b0, 1'b0, 1'b1, 5'd12, 32'hA5A5_5A5A, 5'd12, 5'd12);
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
        idle(9, 5'd12, 5'd1);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
        idle(CLR_CYCLES + 3, 5'd12, 5'd30);

        // clr_req held high: one window, one idle cycle, then a fresh window.
        for (int i = 0; i < 2 * CLR_CYCLES + 6; i++)
            drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h0BAD_0000 + 32'(i), 5'd6, 5'd6);
        idle(CLR_CYCLES + 2, 5'd6, 5'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [4:0]  wa, a1, a2;
            logic        rst, clr, we;
            wa  = 5'($urandom_range(0, 31));
            we  = $urandom_range(0, 1) == 1;
            rst = $urandom_range(0, 599) == 0;
            clr = $urandom_range(0, 79) == 0;
            a1  = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(rst, clr, we, wa, $urandom, a1, a2);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w_clr.md
REGFILE_2R1W_CLR -- requirements
Module: regfile_2r1w_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter ADDR_W, default 5, address bits; DEPTH = 2**ADDR_W registers, ADDR_W >= 1.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port clr_req_i  in  1  request to zero the whole file.
REQ-006 SHALL have port we_i  in  1  write enable.
REQ-007 SHALL have port waddr_i  in  ADDR_W  write address.
REQ-008 SHALL have port wdata_i  in  WIDTH  write data.
REQ-009 SHALL have ports raddr1_i and raddr2_i  in  ADDR_W  read addresses.
REQ-010 SHALL have ports rdata1_o and rdata2_o  out  WIDTH  read data.
REQ-011 SHALL have port busy_o  out  1  clear sequence in progress.

Function
REQ-012 Reads SHALL be combinational from the array, with zero latency and independent ports.
REQ-013 Register 0 SHALL always read as 0, regardless of writes or clear state.
REQ-014 A write SHALL be accepted at a rising edge only when we_i=1, waddr_i!=0 and busy_o=0.
- An accepted write becomes visible to reads after that edge.
REQ-015 The clear FSM SHALL have exactly two states:
- IDLE: busy_o=0.
- CLEAR: busy_o=1.
REQ-016 A clear counter cnt (ADDR_W bits) SHALL step through the file in CLEAR:
- Each edge writes 0 to entry cnt and increments cnt.
- The edge that writes entry DEPTH-1 returns the FSM to IDLE.
REQ-017 A full clear SHALL take exactly DEPTH-1 cycles in CLEAR.
REQ-018 In IDLE, clr_req_i=1 at an edge SHALL move the FSM to CLEAR with cnt=1.
- A write accepted on the same edge is performed, then overwritten by the sequence.
REQ-019 In CLEAR, clr_req_i SHALL be ignored; the sequence does not restart.
REQ-020 While busy_o=1, rdata1_o and rdata2_o SHALL read 0, so uncleared or X contents never leak.
REQ-021 While busy_o=1, we_i SHALL be ignored: the write is dropped and no stall or queueing occurs.
REQ-022 With DEPTH=2, the clear SHALL be a single cycle writing entry 1.

Reset
REQ-023 rst_i=1 at an edge SHALL force state CLEAR, cnt=1 and busy_o=1, and block writes.
REQ-024 The clear sequence SHALL begin on the first edge with rst_i=0.
- busy_o deasserts DEPTH-1 cycles later; the file then reads all zero.
REQ-025 Reset asserted mid-clear SHALL restart the sequence from cnt=1.
REQ-026 Reset SHALL NOT clear array contents directly; zeroing is done only by the sequence.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control same-cycle write-to-read forwarding.
- Defined: when a write is accepted (REQ-014) and raddrN_i==waddr_i, rdataN_o SHALL equal wdata_i in that same cycle, combinationally.
- Undefined: rdataN_o SHALL show the old contents until the edge.
REQ-028 Bypass SHALL never apply to address 0 or while busy_o=1, in either build.

Verification (WIDTH=32, ADDR_W=5)
REQ-029 Reset clear: rst_i high 2 cycles then low -> busy_o=1 for exactly 31 cycles, then 0; all 32 addresses read 0x00000000.
REQ-030 Basic write: write 0xDEADBEEF to r5, then write 0x12345678 to r0 -> next cycle r5 reads 0xDEADBEEF and r0 reads 0 on both ports.
REQ-031 Same-cycle read/write: write 0xCAFEF00D to r7 with raddr1=raddr2=7 in the same cycle.
- With REGFILE_BYPASS_EN: both ports show 0xCAFEF00D that cycle.
- Without it: both ports show the prior value 0x00000000.
REQ-032 Clear request: r9=0x11111111 in IDLE; pulse clr_req_i together with a write of 0x22222222 to r10.
- busy_o is 1 for 31 cycles.
- During busy, reads return 0 and a write of 0x33333333 to r3 is dropped.
- Afterward r3, r9 and r10 all read 0.
REQ-033 Reset mid-clear: assert rst_i at cycle 10 of a clear, then release -> busy_o stays 1 for a further 31 cycles after release.
REQ-034 Re-request during clear: clr_req_i held high throughout a clear -> exactly one 31-cycle busy window, then the FSM re-enters CLEAR on the next IDLE edge.
